// File: rtl/tile_board_drawer_if.sv
// tile_board_drawer_if: connects the game FSM and the board drawer.
//   start      - single-cycle redraw request (game -> drawer)
//   row0..row3 - tile rows, top to bottom; bit 3 is the leftmost column
//   VGA_X/Y    - pixel coordinates toward the vga_adapter
//   VGA_COLOR  - pixel colour toward the vga_adapter
//   plot       - pixel write strobe
//   busy       - drawer is loading, drawing or finishing
//   done       - one-cycle pulse after the final pixel
// master: game side; slave: drawer side.
interface tile_board_drawer_if;
   logic       start;
   logic [3:0] row0;
   logic [3:0] row1;
   logic [3:0] row2;
   logic [3:0] row3;
   logic [9:0] VGA_X;
   logic [8:0] VGA_Y;
   logic [2:0] VGA_COLOR;
   logic       plot;
   logic       busy;
   logic       done;

   modport master (
      output start, row0, row1, row2, row3,
      input  VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
   );

   modport slave (
      input  start, row0, row1, row2, row3,
      output VGA_X, VGA_Y, VGA_COLOR, plot, busy, done
   );
endinterface

// File: rtl/tile_board_drawer.sv
// tile_board_drawer: redraws the 4x4 piano-tile board into the VGA frame
// buffer, one pixel per clock, in raster order (pixel, column, line, row).
// Ports:
//   CLOCK_50 - system clock, rising edge
//   reset    - asynchronous, active-high
//   bus      - slave side of tile_board_drawer_if (start/rows in,
//              VGA_X/VGA_Y/VGA_COLOR/plot/busy/done out)
module tile_board_drawer #(
   parameter int unsigned TILE_W       = 40,
   parameter int unsigned TILE_H       = 30,
   parameter logic [9:0]  X0           = 10'd0,
   parameter logic [8:0]  Y0           = 9'd0,
   parameter logic [2:0]  TILE_COLOR   = 3'b000,
   parameter logic [2:0]  BG_COLOR     = 3'b111,
   parameter logic [2:0]  BORDER_COLOR = 3'b100
) (
   input logic                CLOCK_50,
   input logic                reset,
   tile_board_drawer_if.slave bus
);
   localparam int unsigned   PxW    = $clog2(TILE_W);
   localparam int unsigned   PyW    = $clog2(TILE_H);
   localparam logic [PxW-1:0] PxLast = PxW'(TILE_W - 1);
   localparam logic [PyW-1:0] PyLast = PyW'(TILE_H - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StDraw, StDone} state_e;

   state_e         state_q, state_d;
   logic [PxW-1:0] px_q;
   logic [1:0]     col_q;
   logic [PyW-1:0] py_q;
   logic [1:0]     row_q;
   logic [9:0]     x_q;
   logic [8:0]     y_q;
   logic [3:0]     snap_q [4];
   logic [9:0]     vga_x_q;
   logic [8:0]     vga_y_q;
   logic [2:0]     vga_color_q;
   logic           plot_q;
   logic           done_q;

   logic           px_end;
   logic           py_end;
   logic           line_end;
   logic           last_pix;
   logic [3:0]     cur_row;
   logic [2:0]     color_d;

   assign px_end   = (px_q == PxLast);
   assign py_end   = (py_q == PyLast);
   assign line_end = px_end && (col_q == 2'd3);
   assign last_pix = line_end && py_end && (row_q == 2'd3);
   assign cur_row  = snap_q[row_q];

   // Border wins over tile content; bit 3 of a row is the leftmost column.
   always_comb begin
      color_d = BG_COLOR;
      if (px_end || py_end) begin
         color_d = BORDER_COLOR;
      end else if (cur_row[2'd3 - col_q]) begin
         color_d = TILE_COLOR;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StLoad;
         StLoad:  state_d = StDraw;
         StDraw:  if (last_pix) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         px_q        <= '0;
         col_q       <= '0;
         py_q        <= '0;
         row_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         snap_q[0]   <= '0;
         snap_q[1]   <= '0;
         snap_q[2]   <= '0;
         snap_q[3]   <= '0;
         vga_x_q     <= '0;
         vga_y_q     <= '0;
         vga_color_q <= '0;
         plot_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         plot_q <= (state_q == StDraw);
         done_q <= (state_q == StDone);
         if (state_q == StLoad) begin
            snap_q[0] <= bus.row0;
            snap_q[1] <= bus.row1;
            snap_q[2] <= bus.row2;
            snap_q[3] <= bus.row3;
            px_q      <= '0;
            col_q     <= '0;
            py_q      <= '0;
            row_q     <= '0;
            x_q       <= X0;
            y_q       <= Y0;
         end else if (state_q == StDraw) begin
            vga_x_q     <= x_q;
            vga_y_q     <= y_q;
            vga_color_q <= color_d;
            // x runs continuously across the four cells of a line, so it
            // only rewinds to X0 at the end of a full board line.
            if (!px_end) begin
               px_q <= px_q + PxW'(1);
               x_q  <= x_q + 10'd1;
            end else begin
               px_q <= '0;
               if (col_q != 2'd3) begin
                  col_q <= col_q + 2'd1;
                  x_q   <= x_q + 10'd1;
               end else begin
                  col_q <= '0;
                  x_q   <= X0;
                  y_q   <= y_q + 9'd1;
                  if (!py_end) begin
                     py_q <= py_q + PyW'(1);
                  end else begin
                     py_q  <= '0;
                     row_q <= row_q + 2'd1;
                  end
               end
            end
         end
      end
   end

   assign bus.VGA_X     = vga_x_q;
   assign bus.VGA_Y     = vga_y_q;
   assign bus.VGA_COLOR = vga_color_q;
   assign bus.plot      = plot_q;
   assign bus.done      = done_q;
   assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_tile_board_drawer.sv
// Bench for tile_board_drawer: a small 4x2-cell instance for detailed
// checks and a default-parameter instance for the full-size frame.
module tb_tile_board_drawer;
   localparam int SW  = 4;
   localparam int SH  = 2;
   localparam int SX0 = 8;
   localparam int SY0 = 4;
   localparam int SN  = 16 * SW * SH;
   localparam int BW  = 40;
   localparam int BH  = 30;
   localparam int BN  = 16 * BW * BH;

   logic clk = 1'b0;
   logic reset;

   tile_board_drawer_if sb ();
   tile_board_drawer_if bb ();

   tile_board_drawer #(
      .TILE_W (SW),
      .TILE_H (SH),
      .X0     (10'd8),
      .Y0     (9'd4)
   ) u_small (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (sb)
   );

   tile_board_drawer u_big (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bb)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   logic [2:0] fb [0:31][0:15];

   typedef struct {
      int         x;
      int         y;
      logic [2:0] c;
   } pix_vec_t;

   pix_vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference: the i-th pixel of a frame, decomposed from the raster index.
   function automatic logic [21:0] model_pix(input int i, input int w, input int h,
                                             input int x0, input int y0,
                                             input logic [15:0] rows);
      int px  = i % w;
      int col = (i / w) % 4;
      int py  = (i / (4 * w)) % h;
      int row = (i / (4 * w * h)) % 4;
      int x   = x0 + col * w + px;
      int y   = y0 + row * h + py;
      logic [3:0] rv;
      logic [2:0] c;
      rv = rows[15 - 4 * row -: 4];
      if (px == w - 1 || py == h - 1) c = 3'b100;
      else if (rv[3 - col])           c = 3'b000;
      else                            c = 3'b111;
      return {x[9:0], y[8:0], c};
   endfunction

   task automatic set_small_rows(input logic [15:0] rows);
      sb.row0 = rows[15:12];
      sb.row1 = rows[11:8];
      sb.row2 = rows[7:4];
      sb.row3 = rows[3:0];
   endtask

   // One redraw on the small instance; ends on the negedge of the done cycle.
   task automatic run_small(input logic [15:0] rows, input logic [15:0] mid_rows,
                            input bit do_mid, input bit spam, input string tag);
      int plots = 0;
      int first_k = -1;
      int last_k = -1;
      int dones = 0;
      int done_k = -1;
      int busy_bad = 0;
      logic [21:0] act;
      set_small_rows(rows);
      sb.start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < SN + 3; k++) begin
         @(negedge clk);
         if (k == 0) chk({tag, " busy after accept"}, int'(sb.busy), 1);
         if (sb.plot) begin
            if (first_k < 0) first_k = k;
            last_k = k;
            if (!sb.busy) busy_bad++;
            act = {sb.VGA_X, sb.VGA_Y, sb.VGA_COLOR};
            chk($sformatf("%s pixel %0d", tag, plots), int'(act),
                int'(model_pix(plots, SW, SH, SX0, SY0, rows)));
            if (sb.VGA_X < 32 && sb.VGA_Y < 16) fb[sb.VGA_X][sb.VGA_Y] = sb.VGA_COLOR;
            plots++;
         end
         if (sb.done) begin
            dones++;
            done_k = k;
         end
         sb.start = spam && k <= SN && ($urandom_range(0, 3) == 0);
         if (do_mid && k == 20) set_small_rows(mid_rows);
      end
      sb.start = 1'b0;
      chk({tag, " plot count"}, plots, SN);
      chk({tag, " first plot cycle"}, first_k, 2);
      chk({tag, " last plot cycle"}, last_k, SN + 1);
      chk({tag, " done count"}, dones, 1);
      chk({tag, " done cycle"}, done_k, SN + 2);
      chk({tag, " busy low while plotting"}, busy_bad, 0);
   endtask

   initial begin
      logic [15:0] r;
      logic [15:0] rb;
      int plots;
      int bad;
      int maxx;
      int maxy;
      int done_k;
      logic [21:0] act;

      reset = 1'b1;
      sb.start = 1'b0;
      bb.start = 1'b0;
      set_small_rows(16'h0000);
      bb.row0 = '0; bb.row1 = '0; bb.row2 = '0; bb.row3 = '0;
      repeat (3) @(negedge clk);
      chk("reset VGA_X", int'(sb.VGA_X), 0);
      chk("reset VGA_Y", int'(sb.VGA_Y), 0);
      chk("reset VGA_COLOR", int'(sb.VGA_COLOR), 0);
      chk("reset plot", int'(sb.plot), 0);
      chk("reset busy", int'(sb.busy), 0);
      chk("reset done", int'(sb.done), 0);
      // start together with reset: reset wins
      sb.start = 1'b1;
      @(negedge clk);
      sb.start = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("start under reset busy", int'(sb.busy), 0);

      run_small(16'h0000, 16'h0000, 1'b0, 1'b0, "blank");
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (sb.plot || sb.busy || sb.done) bad++;
      end
      chk("idle after frame", bad, 0);

      run_small(16'h8001, 16'h0000, 1'b0, 1'b0, "pattern");
      tbl.push_back('{8, 4, 3'b000});
      tbl.push_back('{11, 4, 3'b100});
      tbl.push_back('{20, 10, 3'b000});
      tbl.push_back('{12, 4, 3'b111});
      tbl.push_back('{23, 11, 3'b100});
      for (int x = 8; x < 24; x++) tbl.push_back('{x, 5, 3'b100});
      foreach (tbl[i])
         chk($sformatf("fb(%0d,%0d)", tbl[i].x, tbl[i].y), int'(fb[tbl[i].x][tbl[i].y]),
             int'(tbl[i].c));

      // Row changes mid-frame must not reach the frame; next frame sees them.
      run_small(16'h8001, 16'hF001, 1'b1, 1'b0, "snapshot");
      run_small(16'hF001, 16'h0000, 1'b0, 1'b0, "after change");

      // Start spam during busy, then a start right after done.
      run_small(16'h4812, 16'h0000, 1'b0, 1'b1, "spam");
      run_small(16'h2481, 16'h0000, 1'b0, 1'b0, "back to back");

      // Reset after the 50th plot.
      set_small_rows(16'hA5A5);
      sb.start = 1'b1;
      @(negedge clk);
      sb.start = 1'b0;
      plots = 0;
      for (int k = 0; k < 200 && plots < 50; k++) begin
         @(negedge clk);
         if (sb.plot) plots++;
      end
      chk("plots before reset", plots, 50);
      reset = 1'b1;
      #1;
      chk("async reset plot", int'(sb.plot), 0);
      chk("async reset busy", int'(sb.busy), 0);
      chk("async reset done", int'(sb.done), 0);
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (sb.plot || sb.done || sb.busy) bad++;
      end
      chk("quiet after reset", bad, 0);
      run_small(16'h5A5A, 16'h0000, 1'b0, 1'b0, "post reset");

      for (int t = 0; t < 6; t++) begin
         r  = 16'($urandom);
         rb = 16'($urandom);
         run_small(r, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $sformatf("rand%0d", t));
      end

      // Full-size frame on the default instance.
      r = 16'($urandom);
      bb.row0 = r[15:12]; bb.row1 = r[11:8]; bb.row2 = r[7:4]; bb.row3 = r[3:0];
      bb.start = 1'b1;
      @(posedge clk);
      plots = 0; bad = 0; maxx = 0; maxy = 0; done_k = -1;
      for (int k = 0; k < BN + 5; k++) begin
         @(negedge clk);
         bb.start = 1'b0;
         if (bb.plot) begin
            act = {bb.VGA_X, bb.VGA_Y, bb.VGA_COLOR};
            if (act != model_pix(plots, BW, BH, 0, 0, r)) begin
               if (bad < 5)
                  chk($sformatf("big pixel %0d", plots), int'(act),
                      int'(model_pix(plots, BW, BH, 0, 0, r)));
               bad++;
            end
            if (int'(bb.VGA_X) > maxx) maxx = int'(bb.VGA_X);
            if (int'(bb.VGA_Y) > maxy) maxy = int'(bb.VGA_Y);
            plots++;
         end
         if (bb.done && done_k < 0) done_k = k;
      end
      chk("big pixel errors", bad, 0);
      chk("big plot count", plots, BN);
      chk("big max x", maxx, 159);
      chk("big max y", maxy, 119);
      chk("big done cycle", done_k, BN + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/tile_board_drawer.md
Name: tile_board_drawer

Overview:
- Renders the 4x4 piano-tile board into the VGA frame buffer.
- Consumes the four tile-row shift-register values (top row through bottom row) held by the game-state/shift logic.
- Emits one pixel write per clock to the vga_adapter: x, y, colour, write.
- A start pulse triggers one full-board redraw. The block pulses done when finished, so the game FSM can advance (shift/spawn) only after the screen is consistent.

Parameters:
- TILE_W, 40, tile width in pixels (>=2)
- TILE_H, 30, tile height in pixels (>=2)
- X0, 0, board left edge x (10-bit)
- Y0, 0, board top edge y (9-bit)
- TILE_COLOR, 3'b000, colour of a set tile (black)
- BG_COLOR, 3'b111, colour of an empty cell (white)
- BORDER_COLOR, 3'b100, colour of the cell grid lines (last pixel column and last pixel row of every cell)

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle redraw request; sampled only in IDLE
- row0  in  4  top tile row; bit 3 = leftmost column
- row1  in  4  second tile row
- row2  in  4  third tile row
- row3  in  4  bottom (hit) tile row
- VGA_X  out  10  pixel x to vga_adapter
- VGA_Y  out  9  pixel y to vga_adapter
- VGA_COLOR  out  3  pixel colour to vga_adapter
- plot  out  1  pixel write strobe (vga_adapter write)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final pixel

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is asynchronous, active-high.
- Reset values: state=IDLE; VGA_X=0; VGA_Y=0; VGA_COLOR=0; plot=0; busy=0; done=0; all counters 0; snapshot regs 0.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: one cycle. Snapshot row0..row3 into internal regs; later input changes do not affect the frame. Clear counters. -> DRAW.
  - DRAW: one pixel per cycle. After the last pixel -> DONE.
  - DONE: one cycle; done=1. -> IDLE.
- busy=1 in LOAD, DRAW and DONE.
- start is ignored while busy; no queuing.
- Counters: px_in (0..TILE_W-1), col (0..3), py_in (0..TILE_H-1), row (0..3).
  - Raster order: px_in increments every DRAW cycle.
  - px_in wraps at TILE_W-1 -> col++.
  - col wraps at 3 -> py_in++.
  - py_in wraps at TILE_H-1 -> row++.
  - Last pixel: row=3, py_in=TILE_H-1, col=3, px_in=TILE_W-1.
  - No dividers or multipliers on the x/y path. Use running x/y accumulators: x resets to X0 at each line start and increments by 1; y increments by 1 per line.
- Pixel outputs: registered. Each DRAW cycle drives plot=1 with VGA_X/VGA_Y/VGA_COLOR for the current counters on the following edge. First pixel appears on the cycle after the first DRAW cycle.
- Total plot cycles: exactly 16*TILE_W*TILE_H per redraw, no gaps, no duplicates.
- Pixel coordinates:
  - VGA_X = X0 + col*TILE_W + px_in, truncated to 10 bits.
  - VGA_Y = Y0 + row*TILE_H + py_in, truncated to 9 bits.
  - Parameter choice must keep the board on-screen (160x120 or 320x240); no clipping logic.
- Colour priority:
  - px_in==TILE_W-1 or py_in==TILE_H-1 -> BORDER_COLOR.
  - else if snapshot[row][3-col]==1 -> TILE_COLOR.
  - else BG_COLOR.
- done: asserted in the cycle after the final plot=1 cycle.
- plot: 0 whenever not emitting a pixel.
- Timing from start high at edge 0:
  - LOAD at edge 1, first DRAW at edge 2.
  - First plot visible after edge 3; last plot after edge 2+N (N = 16*TILE_W*TILE_H).
  - done after edge 3+N.
- Reset mid-DRAW: plot, busy and done drop immediately (async); state returns to IDLE. No partial done pulse. The next start redraws from pixel (X0,Y0).
- start and reset together: reset wins.

Test Plan:
- Reset with TILE_W=4, TILE_H=2, X0=8, Y0=4; rows=0; start pulse -> exactly 128 plot cycles, no gaps. First pixel (8,4). Last pixel (23,11). done pulses once, one cycle after the last plot. busy spans LOAD..DONE.
- Same params; row0=4'b1000, row3=4'b0001, others 0 -> pixel (8,4)=3'b000. Pixel (11,4)=3'b100 (border column). Pixel (20,10)=3'b000. Pixel (12,4)=3'b111. Row py_in=1 (y=5) all 3'b100.
- Change row0 to 4'b1111 mid-draw -> frame colours still match the snapshot taken in LOAD. Next redraw reflects 4'b1111.
- Assert start repeatedly during busy -> plot count remains 128, one done. A start one cycle after done -> a second full frame.
- Assert reset after the 50th plot -> plot/busy drop at once, no done. A later start yields 128 plots beginning at (8,4).
- Default params (40x30, X0=Y0=0) -> 19200 plot cycles. Max pixel (159,119). done at cycle 3+19200 after start.
